// File: rtl/shape_processor_pkg.sv
// Shared types, STATUS layout and CTRL field rules for the shape processor SFR block.
package shape_processor_pkg;

   typedef enum logic [2:0] {
      CIRCLE     = 3'd0,
      RECTANGLE  = 3'd1,
      TRIANGLE   = 3'd2,
      KEEP_SHAPE = 3'd7
   } shape_e;

   typedef enum logic [2:0] {
      PERIMETER      = 3'd0,
      AREA           = 3'd1,
      IS_SQUARE      = 3'd2,
      IS_EQUILATERAL = 3'd3,
      IS_ISOSCELES   = 3'd4,
      KEEP_OPERATION = 3'd7
   } operation_e;

   typedef struct packed {
      operation_e operation;
      shape_e     shape;
   } ctrl_sfr_reg;

   localparam ctrl_sfr_reg CTRL_RESET = '{operation: PERIMETER, shape: CIRCLE};

   // STATUS bit positions
   localparam int ST_RSV_SHAPE = 0;
   localparam int ST_RSV_OP    = 1;
   localparam int ST_ILLEGAL   = 2;
   localparam int ST_BAD_ADDR  = 3;
   localparam int ST_BUSY_REJ  = 4;
   localparam int ST_CNT_LSB   = 8;
   localparam int ST_BUSY      = 16;
   localparam int STICKY_W     = 5;

   function automatic logic is_reserved_shape(logic [2:0] s);
      return (s >= 3'd3) && (s <= 3'd6);
   endfunction

   function automatic logic is_reserved_operation(logic [2:0] o);
      return (o == 3'd5) || (o == 3'd6);
   endfunction

   function automatic logic is_legal_combination(shape_e s, operation_e o);
      logic ok;
      ok = 1'b0;
      case (s)
         CIRCLE:    ok = (o == PERIMETER) || (o == AREA);
         RECTANGLE: ok = (o == PERIMETER) || (o == AREA) || (o == IS_SQUARE);
         TRIANGLE:  ok = (o == PERIMETER) || (o == AREA) ||
                         (o == IS_EQUILATERAL) || (o == IS_ISOSCELES);
         default:   ok = 1'b0;
      endcase
      return ok;
   endfunction

   // KEEP_* fields take the value currently held by the register being written.
   function automatic ctrl_sfr_reg resolve_keep(logic [6:0] fields, ctrl_sfr_reg cur);
      ctrl_sfr_reg r;
      r.shape     = (fields[2:0] == 3'd7) ? cur.shape     : shape_e'(fields[2:0]);
      r.operation = (fields[6:4] == 3'd7) ? cur.operation : operation_e'(fields[6:4]);
      return r;
   endfunction

   function automatic logic [31:0] ctrl_to_word(ctrl_sfr_reg c);
      return {25'd0, c.operation, 1'b0, c.shape};
   endfunction

endpackage

// File: rtl/shape_processor_ctrl_check.sv
// Resolves KEEP fields of a CTRL write against the target register and flags rejections.
module shape_processor_ctrl_check
   import shape_processor_pkg::*;
(
   input  logic [31:0] write_data_i,
   input  ctrl_sfr_reg current_i,
   output ctrl_sfr_reg resolved_o,
   output logic        rsv_shape_o,
   output logic        rsv_op_o,
   output logic        illegal_o
);

   logic unused_wdata;
   assign unused_wdata = ^{write_data_i[31:7], write_data_i[3]};

   assign resolved_o  = resolve_keep(write_data_i[6:0], current_i);
   assign rsv_shape_o = is_reserved_shape(write_data_i[2:0]);
   assign rsv_op_o    = is_reserved_operation(write_data_i[6:4]);
   // Combination is only judged once both fields are known-good encodings.
   assign illegal_o   = !rsv_shape_o && !rsv_op_o &&
                        !is_legal_combination(resolved_o.shape, resolved_o.operation);

endmodule

// File: rtl/shape_processor_mc.sv
// Multi-channel shape CTRL register file with STATUS, optional shadow set and commit FSM.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no commit running, channel and COMMIT writes accepted
// S_COMMIT  | copying shadow[ch_cnt_q] -> active[ch_cnt_q], one per cycle
module shape_processor_mc
   import shape_processor_pkg::*;
#(
   parameter int NUM_CHANNELS = 4,
   parameter int SHADOWED     = 1,
   localparam int ADDR_W      = $clog2(NUM_CHANNELS + 2)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              write,
   input  logic [ADDR_W-1:0] address,
   input  logic [31:0]       write_data,
   input  logic              read,
   output logic [31:0]       read_data,
   output logic              error,
   output logic              busy
);

   localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(NUM_CHANNELS);
   localparam logic [ADDR_W-1:0] A_COMMIT = ADDR_W'(NUM_CHANNELS + 1);
   localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NUM_CHANNELS - 1);

   typedef enum logic {S_IDLE, S_COMMIT} state_e;

   state_e            state_q;
   logic [CH_W-1:0]   ch_cnt_q;
   logic              busy_q;
   ctrl_sfr_reg       active_q [NUM_CHANNELS];
   ctrl_sfr_reg       shadow_q [NUM_CHANNELS];
   logic [STICKY_W-1:0] sticky_q, sticky_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              error_q, error_d;
   logic [31:0]       read_data_q, read_data_d;

   logic              is_ch, is_status, is_commit, is_bad;
   logic [CH_W-1:0]   ch_idx;
   ctrl_sfr_reg       cur_target, resolved;
   logic              rsv_shape, rsv_op, illegal;
   logic [STICKY_W-1:0] rej;
   logic              ch_wr, commit_go, stat_wr;
   logic [7:0]        cnt_base;
   logic [31:0]       status_word;

   assign is_ch     = address < A_STATUS;
   assign is_status = address == A_STATUS;
   assign is_commit = address == A_COMMIT;
   assign is_bad    = address > A_COMMIT;
   assign ch_idx    = address[CH_W-1:0];
   assign stat_wr   = write && is_status;

   // KEEP resolves against whichever register set a channel write lands in.
   always_comb begin
      cur_target = CTRL_RESET;
      if (is_ch) begin
         cur_target = (SHADOWED != 0) ? shadow_q[ch_idx] : active_q[ch_idx];
      end
   end

   shape_processor_ctrl_check u_check (
      .write_data_i (write_data),
      .current_i    (cur_target),
      .resolved_o   (resolved),
      .rsv_shape_o  (rsv_shape),
      .rsv_op_o     (rsv_op),
      .illegal_o    (illegal)
   );

   // Access decode: rejection causes, accepted channel writes and commit launch.
   always_comb begin
      rej       = '0;
      ch_wr     = 1'b0;
      commit_go = 1'b0;
      if (write) begin
         if (is_ch) begin
            if (busy_q) begin
               rej[ST_BUSY_REJ] = 1'b1;
            end else begin
               rej[ST_RSV_SHAPE] = rsv_shape;
               rej[ST_RSV_OP]    = rsv_op;
               rej[ST_ILLEGAL]   = illegal;
               ch_wr = !(rsv_shape || rsv_op || illegal);
            end
         end else if (is_commit) begin
            if (SHADOWED == 0) begin
               rej[ST_BAD_ADDR] = 1'b1;
            end else if (busy_q) begin
               rej[ST_BUSY_REJ] = 1'b1;
            end else begin
               commit_go = write_data[0];
            end
         end else if (is_bad) begin
            rej[ST_BAD_ADDR] = 1'b1;
         end
      end
      if (read && is_bad) begin
         rej[ST_BAD_ADDR] = 1'b1;
      end
   end

   // STATUS next state: clear first so a same-cycle rejection wins; reads see pre-write values.
   always_comb begin
      sticky_d = sticky_q & ~(stat_wr ? write_data[STICKY_W-1:0] : '0);
      sticky_d = sticky_d | rej;
      cnt_base = (stat_wr && write_data[8]) ? 8'd0 : cnt_q;
      cnt_d    = ((|rej) && (cnt_base != 8'hFF)) ? cnt_base + 8'd1 : cnt_base;
      error_d  = |rej;
      status_word = {15'd0, busy_q, cnt_q, 3'd0, sticky_q};
      read_data_d = read_data_q;
      if (read) begin
         if (is_ch) begin
            read_data_d = ctrl_to_word(active_q[ch_idx]);
         end else if (is_status) begin
            read_data_d = status_word;
         end else begin
            read_data_d = 32'd0;
         end
      end
   end

   // Commit sequencer: walks every channel once, busy mirrors the COMMIT state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         ch_cnt_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (commit_go) begin
                  state_q  <= S_COMMIT;
                  ch_cnt_q <= '0;
                  busy_q   <= 1'b1;
               end
            end
            S_COMMIT: begin
               if (ch_cnt_q == CH_LAST) begin
                  state_q  <= S_IDLE;
                  ch_cnt_q <= '0;
                  busy_q   <= 1'b0;
               end else begin
                  ch_cnt_q <= ch_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q  <= S_IDLE;
               ch_cnt_q <= '0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   // Channel register sets: accepted writes and commit copies.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            active_q[i] <= CTRL_RESET;
            shadow_q[i] <= CTRL_RESET;
         end
      end else begin
         if (ch_wr) begin
            if (SHADOWED != 0) begin
               shadow_q[ch_idx] <= resolved;
            end else begin
               active_q[ch_idx] <= resolved;
            end
         end
         if (state_q == S_COMMIT) begin
            active_q[ch_cnt_q] <= shadow_q[ch_cnt_q];
         end
      end
   end

   // STATUS, error pulse and read data registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q    <= '0;
         cnt_q       <= '0;
         error_q     <= 1'b0;
         read_data_q <= '0;
      end else begin
         sticky_q    <= sticky_d;
         cnt_q       <= cnt_d;
         error_q     <= error_d;
         read_data_q <= read_data_d;
      end
   end

   assign read_data = read_data_q;
   assign error     = error_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_shape_processor_mc.sv
// Bench for shape_processor_mc: one direct-write and one shadowed instance, scoreboard checked.
module tb_shape_processor_mc;

   localparam int N = 4;

   logic        clk;
   logic        rst_n;
   logic        wr_s    [2];
   logic        rd_s    [2];
   logic [2:0]  addr_s  [2];
   logic [31:0] wdata_s [2];
   logic [31:0] rdata_s [2];
   logic        err_s   [2];
   logic        busy_s  [2];

   shape_processor_mc #(.NUM_CHANNELS(N), .SHADOWED(0)) u_dut_d (
      .clk(clk), .rst_n(rst_n), .write(wr_s[0]), .address(addr_s[0]),
      .write_data(wdata_s[0]), .read(rd_s[0]), .read_data(rdata_s[0]),
      .error(err_s[0]), .busy(busy_s[0]));

   shape_processor_mc #(.NUM_CHANNELS(N), .SHADOWED(1)) u_dut_s (
      .clk(clk), .rst_n(rst_n), .write(wr_s[1]), .address(addr_s[1]),
      .write_data(wdata_s[1]), .read(rd_s[1]), .read_data(rdata_s[1]),
      .error(err_s[1]), .busy(busy_s[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          err;
      int unsigned rdata;
      bit          busy;
   } exp_t;

   exp_t sb_q0[$];
   exp_t sb_q1[$];

   int tests = 0;
   int fails = 0;

   // reference model state, channel values kept as CTRL words
   int unsigned act_m  [2][N];
   int unsigned shd_m  [2][N];
   int unsigned sticky_m [2];
   int unsigned cnt_m  [2];
   int unsigned left_m [2];
   int unsigned idx_m  [2];
   int unsigned rdh_m  [2];

   // pending stimulus for the next cycle
   bit          st_wr   [2];
   bit          st_rd   [2];
   int unsigned st_addr [2];
   int unsigned st_data [2];

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic bit legal(int unsigned sh, int unsigned op);
      case (sh)
         0: return (op == 0) || (op == 1);
         1: return op <= 2;
         2: return (op <= 1) || (op == 3) || (op == 4);
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         for (int c = 0; c < N; c++) begin
            act_m[s][c] = 0;
            shd_m[s][c] = 0;
         end
         sticky_m[s] = 0; cnt_m[s] = 0; left_m[s] = 0; idx_m[s] = 0; rdh_m[s] = 0;
         st_wr[s] = 0; st_rd[s] = 0; st_addr[s] = 0; st_data[s] = 0;
         wr_s[s] = 0; rd_s[s] = 0; addr_s[s] = 0; wdata_s[s] = 0;
      end
      sb_q0.delete();
      sb_q1.delete();
   endtask

   // Drive one instance for this cycle and predict its outputs after the edge.
   task automatic apply(int s);
      int unsigned set, a, d, sh, op, cur, rsh, rop;
      bit busy_now, shadowed;
      exp_t e;
      set = 0;
      a = st_addr[s];
      d = st_data[s];
      busy_now = left_m[s] > 0;
      shadowed = (s == 1);
      wr_s[s] = st_wr[s];
      rd_s[s] = st_rd[s];
      addr_s[s] = 3'(a);
      wdata_s[s] = d;
      if (st_rd[s]) begin
         if (a < N) rdh_m[s] = act_m[s][a];
         else if (a == N) rdh_m[s] = (int'(busy_now) << 16) | (cnt_m[s] << 8) | sticky_m[s];
         else if (a == N + 1) rdh_m[s] = 0;
         else begin rdh_m[s] = 0; set |= 8; end
      end
      if (st_wr[s]) begin
         if (a < N) begin
            if (busy_now) set |= 16;
            else begin
               sh = d & 7;
               op = (d >> 4) & 7;
               cur = shadowed ? shd_m[s][a] : act_m[s][a];
               if (sh >= 3 && sh <= 6) set |= 1;
               if (op == 5 || op == 6) set |= 2;
               if ((set & 3) == 0) begin
                  rsh = (sh == 7) ? (cur & 7) : sh;
                  rop = (op == 7) ? ((cur >> 4) & 7) : op;
                  if (!legal(rsh, rop)) set |= 4;
                  else if (shadowed) shd_m[s][a] = (rop << 4) | rsh;
                  else act_m[s][a] = (rop << 4) | rsh;
               end
            end
         end else if (a == N) begin
            sticky_m[s] &= ~(d & 32'h1F);
            if (d & 32'h100) cnt_m[s] = 0;
         end else if (a == N + 1) begin
            if (!shadowed) set |= 8;
            else if (busy_now) set |= 16;
            else if (d & 1) begin left_m[s] = N + 1; idx_m[s] = 0; end
         end else set |= 8;
      end
      if (busy_now) begin
         act_m[s][idx_m[s]] = shd_m[s][idx_m[s]];
         idx_m[s]++;
      end
      if (left_m[s] > 0) left_m[s]--;
      sticky_m[s] |= set;
      if (set != 0 && cnt_m[s] < 255) cnt_m[s]++;
      e.err = (set != 0);
      e.rdata = rdh_m[s];
      e.busy = (left_m[s] > 0);
      if (s == 0) sb_q0.push_back(e); else sb_q1.push_back(e);
   endtask

   task automatic set_op(int s, bit w, bit r, int unsigned a, int unsigned d);
      st_wr[s] = w; st_rd[s] = r; st_addr[s] = a; st_data[s] = d;
   endtask

   task automatic step();
      @(negedge clk);
      apply(0);
      apply(1);
      @(posedge clk);
      #2;
      for (int s = 0; s < 2; s++) begin
         st_wr[s] = 0; st_rd[s] = 0; st_addr[s] = 0; st_data[s] = 0;
      end
   endtask

   // Monitor: pops the prediction for each edge and compares the registered outputs.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n) begin
         if (sb_q0.size() > 0) begin
            e = sb_q0.pop_front();
            check("d0 error", 32'(err_s[0]), 32'(e.err));
            check("d0 read_data", rdata_s[0], e.rdata);
            check("d0 busy", 32'(busy_s[0]), 32'(e.busy));
         end
         if (sb_q1.size() > 0) begin
            e = sb_q1.pop_front();
            check("d1 error", 32'(err_s[1]), 32'(e.err));
            check("d1 read_data", rdata_s[1], e.rdata);
            check("d1 busy", 32'(busy_s[1]), 32'(e.busy));
         end
      end
   end

   task automatic check_zero_outputs(string tag);
      for (int s = 0; s < 2; s++) begin
         check($sformatf("%s d%0d read_data", tag, s), rdata_s[s], 32'd0);
         check($sformatf("%s d%0d error", tag, s), 32'(err_s[s]), 32'd0);
         check($sformatf("%s d%0d busy", tag, s), 32'(busy_s[s]), 32'd0);
      end
   endtask

   task automatic read_all_channels();
      for (int c = 0; c < N + 2; c++) begin
         set_op(0, 0, 1, c, 0);
         set_op(1, 0, 1, c, 0);
         step();
      end
   endtask

   initial begin
      int unsigned d, r, a, shp, opp;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      read_all_channels();

      // direct-write instance: basic write/read
      set_op(0, 1, 0, 2, 32'h12); step();
      set_op(0, 0, 1, 2, 0); step();
      check("ch2 readback", rdata_s[0], 32'h12);
      // illegal combination and write-1-to-clear
      set_op(0, 1, 0, 1, 32'h20); step();
      set_op(0, 0, 1, N, 0); step();
      check("status after illegal", rdata_s[0], 32'h104);
      set_op(0, 1, 0, N, 32'h104); step();
      set_op(0, 0, 1, N, 0); step();
      check("status cleared", rdata_s[0], 32'h0);
      // KEEP resolution
      set_op(0, 1, 0, 0, 32'h11); step();
      set_op(0, 1, 0, 0, 32'h27); step();
      set_op(0, 0, 1, 0, 0); step();
      check("keep shape", rdata_s[0], 32'h21);
      set_op(0, 1, 0, 0, 32'h37); step();
      set_op(0, 0, 1, N, 0); step();
      check("keep shape illegal", rdata_s[0], 32'h104);
      // same-address read/write returns old value; bad address read+write
      set_op(0, 1, 1, 2, 32'h01); step();
      check("read before write", rdata_s[0], 32'h12);
      set_op(0, 1, 1, 7, 32'h0); step();
      set_op(0, 1, 0, N + 1, 32'h1); step();
      set_op(0, 0, 1, N, 0); step();

      // shadowed instance: shadow writes, commit, busy rejection
      for (int c = 0; c < N; c++) begin set_op(1, 1, 0, c, 32'h11); step(); end
      read_all_channels();
      set_op(1, 1, 0, N + 1, 32'h0); step();
      set_op(1, 1, 0, N + 1, 32'h1); step();
      set_op(1, 1, 0, 0, 32'h12); step();
      set_op(1, 0, 1, 1, 0); step();
      set_op(1, 0, 1, N, 0); step();
      set_op(1, 0, 1, N, 0); step();
      set_op(1, 0, 1, 3, 0); step();
      check("committed ch3", rdata_s[1], 32'h11);
      set_op(1, 0, 1, N, 0); step();
      check("busy reject status", rdata_s[1], 32'h110);

      // reset in the middle of a commit
      for (int c = 0; c < N; c++) begin set_op(1, 1, 0, c, 32'h12); step(); end
      set_op(1, 1, 0, N + 1, 32'h1); step();
      step();
      step();
      @(negedge clk);
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      check_zero_outputs("mid-commit reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      read_all_channels();

      // counter saturation
      set_op(0, 1, 0, N, 32'h11F); step();
      for (int i = 0; i < 256; i++) begin set_op(0, 1, 0, 1, 32'h05); step(); end
      set_op(0, 0, 1, N, 0); step();
      check("counter saturated", rdata_s[0], 32'hFF01);

      // random traffic on both instances
      for (int i = 0; i < 1500; i++) begin
         for (int s = 0; s < 2; s++) begin
            r = $urandom_range(0, 9);
            a = $urandom_range(0, 7);
            d = $urandom;
            if ($urandom_range(0, 3) != 0) begin
               shp = $urandom_range(0, 4);
               if (shp > 2) shp = (shp == 3) ? 7 : $urandom_range(3, 6);
               opp = $urandom_range(0, 5);
               if (opp == 5) opp = ($urandom_range(0, 1) != 0) ? 7 : $urandom_range(5, 6);
               d = (d & ~32'h77) | (opp << 4) | shp;
            end
            if (a == N && $urandom_range(0, 3) != 0) a = $urandom_range(0, N - 1);
            set_op(s, r < 5, (r >= 3 && r < 8), a, d);
         end
         step();
      end
      for (int c = 0; c < N + 2; c++) begin
         set_op(0, 0, 1, c, 0); set_op(1, 0, 1, c, 0); step();
      end
      repeat (6) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/shape_processor_mc.md
SHAPE_PROCESSOR_MC -- requirements
Module: shape_processor_mc

Interface
REQ-001 Parameter NUM_CHANNELS, default 4, number of independent CTRL SFRs (legal range 1..16).
REQ-002 Parameter SHADOWED, default 1: 1 = channel writes go to shadow registers and an atomic commit is required; 0 = channel writes go directly to the active registers.
REQ-003 Localparam ADDR_W = $clog2(NUM_CHANNELS+2), word address width.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 write  input  1  write strobe, one transfer per cycle high.
REQ-007 address  input  ADDR_W  word address: 0..N-1 channel CTRL, N STATUS, N+1 COMMIT.
REQ-008 write_data  input  32  write payload.
REQ-009 read  input  1  read strobe.
REQ-010 read_data  output  32  registered read result.
REQ-011 error  output  1  one-cycle pulse flagging a rejected access.
REQ-012 busy  output  1  high while a commit sequence runs.

Function
REQ-013 CTRL layout: SHAPE = [2:0], OPERATION = [6:4], all other bits read 0 and are ignored on write.
REQ-014 SHAPE encodings: CIRCLE=0, RECTANGLE=1, TRIANGLE=2, KEEP_SHAPE=7; 3..6 are reserved.
REQ-015 OPERATION encodings: PERIMETER=0, AREA=1, IS_SQUARE=2, IS_EQUILATERAL=3, IS_ISOSCELES=4, KEEP_OPERATION=7; 5..6 are reserved.
REQ-016 Legal combinations: CIRCLE {PERIMETER, AREA}; RECTANGLE {PERIMETER, AREA, IS_SQUARE}; TRIANGLE {PERIMETER, AREA, IS_EQUILATERAL, IS_ISOSCELES}.
REQ-017 Channel write target: the shadow register when SHADOWED=1, the active register when SHADOWED=0.
REQ-018 KEEP_* fields resolve to the target register's current field value before the legality check.
REQ-019 A channel write with no reserved field and a legal resolved combination updates the target on the next edge.
REQ-020 Any rejected write leaves every register unchanged.
REQ-021 Write rejection causes and their STATUS bits: reserved SHAPE [0]; reserved OPERATION [1]; illegal combination [2]; address > N+1, or COMMIT while SHADOWED=0 [3]; CTRL or COMMIT write while busy [4].
REQ-022 On a rejection, error pulses high for exactly one cycle, the cycle after the write, and the matching sticky STATUS bits set.
REQ-023 STATUS[15:8] is an 8-bit rejection counter that saturates at 255; STATUS[16] reads busy.
REQ-024 A STATUS write clears every sticky bit [4:0] whose write_data bit is 1 (write-1-to-clear); write_data[8] = 1 clears the counter.
REQ-025 A STATUS write is never rejected, including while busy.
REQ-026 If a rejection and a STATUS clear occur in the same cycle, the set wins.
REQ-027 FSM IDLE -> COMMIT: on a COMMIT write with write_data[0]=1 while IDLE and SHADOWED=1; a COMMIT write with write_data[0]=0 is a no-op.
REQ-028 In COMMIT, a channel counter starting at 0 copies shadow[ch] to active[ch] once per cycle.
REQ-029 COMMIT -> IDLE after channel N-1 is copied; busy is high exactly N cycles, starting the cycle after the COMMIT write.
REQ-030 Reads: read_data is updated the cycle after read and holds its value otherwise.
REQ-031 Read of a channel returns the active value, with 0 in unused bits.
REQ-032 Read of STATUS returns STATUS; read of COMMIT returns 0.
REQ-033 Read of address > N+1 returns 0 and is rejected (bit [3], error pulse).
REQ-034 Simultaneous read and write to the same address: the read returns the pre-write value.
REQ-035 A read and a write rejected in the same cycle produce a single error pulse, the counter increments by 1, and all applicable sticky bits set.
REQ-036 Active registers change only on a direct write (SHADOWED=0) or during COMMIT (SHADOWED=1).

Reset
REQ-037 While rst_n is low, asynchronously, all active and shadow channels SHALL be {CIRCLE, PERIMETER}, STATUS=0, FSM=IDLE, counter=0, read_data=0, error=0, busy=0.
REQ-038 Reset asserted mid-commit aborts the sequence, and all channels return to reset values, including those already copied.

Structure
REQ-039 Shared package shape_processor_pkg holds: shape_e, operation_e and ctrl_sfr_reg; the STATUS bit positions; is_reserved_shape, is_reserved_operation and is_legal_combination; and the KEEP resolve function.
REQ-040 One combinational sub-module, shape_processor_ctrl_check, takes write_data and the current target value and returns the resolved value plus the three rejection flags; it is instantiated once, muxed by address.

Verification
REQ-041 N=4, SHADOWED=0: write ch2 0x12 (TRIANGLE, AREA) -> next cycle active[2]=0x12; read ch2 -> read_data=0x12.
REQ-042 Write ch1 0x20 (CIRCLE, IS_SQUARE) -> error pulse, ch1 unchanged, STATUS=0x104; write STATUS 0x104 -> STATUS=0.
REQ-043 ch0={RECTANGLE, AREA}; write ch0 0x27 (KEEP_SHAPE, IS_SQUARE) -> ch0=0x21; write ch0 0x37 (KEEP_SHAPE, IS_EQUILATERAL) -> rejected, bit [2] set.
REQ-044 SHADOWED=1: write ch0..3 = 0x11 -> active registers still 0; COMMIT 0x1 -> busy high 4 cycles, active[ch] becomes 0x11 on cycles 1..4; CTRL write during busy -> error, bit [4] set.
REQ-045 During COMMIT (after 2 channels are copied), assert rst_n low -> all channels 0, busy=0, FSM IDLE.
REQ-046 Issue 256 writes of SHAPE=5 -> STATUS[15:8] saturates at 0xFF, bit [0] set, and one error pulse per write.
